satagtx_clk_seq: RTL and testbench
==================================

# satagtx_clk_seq

Per-lane clock/reset sequencer for multi-lane SATA GTX/GTP tiles, generalising the single-lane usrclk arrangement, where the DCM/PLL reset simply followed the inverted PLL lock-detect. For each of `C_NUM_LANES` lanes it pulses the transceiver reset, waits for tile PLL lock, releases the usrclk DCM/PLL and waits for its lock, then qualifies both locks for a settle window before declaring the lane ready. It adds timeout-and-retry, permanent-fail reporting, lock-loss recovery and a per-lane restart. It sits between the GTX wrapper/usrclk source and the link layer, on a free-running system clock.

## Interface
- `C_NUM_LANES`, 1: number of independent lanes (1..4).
- `C_RST_PULSE`, 16: cycles `gtx_reset_out` is held on each (re)start (≥2).
- `C_LOCK_WAIT`, 1024: consecutive cycles both locks must be high before ready.
- `C_TIMEOUT`, 65536: cycles allowed in WAIT_PLL or WAIT_CLK before a retry.
- `C_MAX_RETRY`, 7: retries allowed before FAIL (1..15).
- `C_CNT_W`, 17: phase counter width; must hold max(`C_RST_PULSE`, `C_LOCK_WAIT`, `C_TIMEOUT`).

Ports:
- `clk`  in  1  free-running sequencer clock.
- `rst_n`  in  1  reset; one clock, asynchronous assert, active-low.
- `plllkdet_in`  in  N  tile PLL lock detect per lane; asynchronous.
- `clksrc_locked_in`  in  N  usrclk DCM/PLL locked per lane; asynchronous.
- `restart_in`  in  N  single-cycle per-lane restart request.
- `gtx_reset_out`  out  N  transceiver reset, active-high.
- `clksrc_reset_out`  out  N  usrclk DCM/PLL reset, active-high.
- `lane_ready_out`  out  N  lane clocks stable.
- `lane_fail_out`  out  N  retries exhausted.
- `loss_cnt_out`  out  8·N  per-lane lock-loss count; lane i at [8i+7:8i].

## Operation
- Both lock inputs pass through 2-flop synchronisers per lane. All decisions use the synchronised values.
- One identical FSM per lane, with its own phase counter and a 4-bit retry counter.
- RESET_GTX: `gtx_reset`=1, `clksrc_reset`=1. Counts `C_RST_PULSE` cycles, then goes to WAIT_PLL.
- WAIT_PLL: `gtx_reset`=0, `clksrc_reset`=1.
  - Synchronised `plllkdet`=1 → WAIT_CLK.
  - After `C_TIMEOUT` cycles without lock → retry.
- WAIT_CLK: `clksrc_reset`=0.
  - Synchronised `locked`=1 → SETTLE.
  - `plllkdet` drop → WAIT_PLL.
  - Timeout → retry.
- SETTLE: counts cycles while both locks are high.
  - Either lock drops → WAIT_PLL, counter cleared.
  - Count reaches `C_LOCK_WAIT` → READY.
- READY: `lane_ready`=1; retry counter cleared on entry.
  - Either lock drops → RESET_GTX next cycle, `lane_ready` falls the same cycle, loss count increments.
- Retry (on timeout):
  - If retry count < `C_MAX_RETRY`: increment it and go to RESET_GTX.
  - Otherwise go to FAIL.
- FAIL: `lane_fail`=1, `gtx_reset`=1, `clksrc_reset`=1. Held until `restart_in` or `rst_n`.
- `restart_in` in any state → RESET_GTX next cycle, clearing the retry counter and `lane_fail`. Restart wins over a simultaneous timeout, lock loss or settle completion.
- Phase counter clears on every state change.
- Loss counter saturates at 255 and is cleared only by `rst_n`.
- Lanes are fully independent; events on one lane never affect another.

## Timing
- Reset values:
  - `gtx_reset_out` and `clksrc_reset_out` all 1s.
  - `lane_ready_out`, `lane_fail_out` and `loss_cnt_out` all 0s.
  - Every FSM in RESET_GTX with counters at 0.
- All outputs are registered.
- Lock input change to FSM reaction: 2 cycles of synchroniser latency, +1 cycle for the registered output.
- `gtx_reset_out` high for exactly `C_RST_PULSE` cycles per attempt.
- Minimum `rst_n` deassert to `lane_ready`: `C_RST_PULSE` + `C_LOCK_WAIT` + 6 cycles, with both locks already high.
- Timeout fires on the `C_TIMEOUT`-th cycle spent in the state. A lock arriving on that same cycle takes priority over the timeout.
- `rst_n` asserted mid-sequence returns every lane to reset values immediately (asynchronously).

## Configuration
- `SATAGTX_CLK_SEQ_STATUS_EN`:
  - Defined: per-lane loss counters are implemented as described.
  - Undefined: counter logic is omitted and `loss_cnt_out` is tied to 0; all sequencing behaviour is unchanged.

## Test plan
Bench parameters: N=2, `C_RST_PULSE`=4, `C_LOCK_WAIT`=8, `C_TIMEOUT`=32, `C_MAX_RETRY`=2.
- Both locks held high from reset → `gtx_reset` high 4 cycles; `lane_ready` rises on both lanes at cycle 4+8+6; `lane_fail` stays 0.
- Lane0 `plllkdet` held 0 → 3 reset pulses, each 32 WAIT_PLL cycles apart; then `lane_fail[0]`=1 with both resets 1; lane1 reaches ready unaffected.
- Lane1 in READY, drop `clksrc_locked[1]` for 1 cycle → `lane_ready[1]` falls 3 cycles later; `loss_cnt[15:8]`=1; new 4-cycle `gtx_reset`; ready again after settle.
- Toggle `plllkdet[0]` low for 1 cycle at settle count 5 → returns to WAIT_PLL; full 8-cycle settle is restarted.
- Lane0 in FAIL, pulse `restart_in[0]` → `lane_fail[0]` clears next cycle and the 4-cycle reset pulse restarts; restart coincident with a timeout in WAIT_CLK → RESET_GTX with retry count 0.
- Build without `SATAGTX_CLK_SEQ_STATUS_EN`, repeat 300 lock losses → `loss_cnt_out` stays 0. With the macro defined → counter saturates at 255.

Source files
------------

// File: rtl/satagtx_clk_seq.sv
// Per-lane GTX/usrclk clock-reset sequencer with timeout/retry, fail latch and lock-loss recovery.
// Define SATAGTX_CLK_SEQ_STATUS_EN to build the per-lane saturating lock-loss counters.
module satagtx_clk_seq #(
    parameter int unsigned C_NUM_LANES = 1,
    parameter int unsigned C_RST_PULSE = 16,
    parameter int unsigned C_LOCK_WAIT = 1024,
    parameter int unsigned C_TIMEOUT   = 65536,
    parameter int unsigned C_MAX_RETRY = 7,
    parameter int unsigned C_CNT_W     = 17
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [C_NUM_LANES-1:0]     plllkdet_in,
    input  logic [C_NUM_LANES-1:0]     clksrc_locked_in,
    input  logic [C_NUM_LANES-1:0]     restart_in,
    output logic [C_NUM_LANES-1:0]     gtx_reset_out,
    output logic [C_NUM_LANES-1:0]     clksrc_reset_out,
    output logic [C_NUM_LANES-1:0]     lane_ready_out,
    output logic [C_NUM_LANES-1:0]     lane_fail_out,
    output logic [8*C_NUM_LANES-1:0]   loss_cnt_out
);

    typedef enum logic [2:0] {
        ST_RESET_GTX,
        ST_WAIT_PLL,
        ST_WAIT_CLK,
        ST_SETTLE,
        ST_READY,
        ST_FAIL
    } state_t;

    localparam logic [C_CNT_W-1:0] RST_LAST    = C_CNT_W'(C_RST_PULSE - 1);
    localparam logic [C_CNT_W-1:0] SETTLE_LAST = C_CNT_W'(C_LOCK_WAIT - 1);
    localparam logic [C_CNT_W-1:0] TO_LAST     = C_CNT_W'(C_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0] CNT_ONE     = C_CNT_W'(1);
    // Lock samples still in the synchroniser were taken while the PLL/DCM was held in
    // reset, so a lock is only trusted from the third cycle after the reset is released.
    localparam logic [C_CNT_W-1:0] STALE       = C_CNT_W'(2);
    localparam logic [3:0]         MAX_RETRY   = 4'(C_MAX_RETRY);

    for (genvar i = 0; i < C_NUM_LANES; i++) begin : g_lane
        logic [1:0]         pll_sync;
        logic [1:0]         clk_sync;
        logic               pll_s;
        logic               clk_s;
        state_t             state;
        state_t             state_nxt;
        logic [C_CNT_W-1:0] cnt;
        logic [C_CNT_W-1:0] cnt_nxt;
        logic [3:0]         retry;
        logic [3:0]         retry_nxt;
        logic               timeout;
        logic               gtx_q;
        logic               clksrc_q;
        logic               ready_q;
        logic               fail_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pll_sync <= '0;
                clk_sync <= '0;
            end else begin
                pll_sync <= {pll_sync[0], plllkdet_in[i]};
                clk_sync <= {clk_sync[0], clksrc_locked_in[i]};
            end
        end

        assign pll_s = pll_sync[1];
        assign clk_s = clk_sync[1];

        always_comb begin
            state_nxt = state;
            retry_nxt = retry;
            timeout   = 1'b0;
            case (state)
                ST_RESET_GTX: begin
                    if (cnt == RST_LAST) state_nxt = ST_WAIT_PLL;
                end
                ST_WAIT_PLL: begin
                    if (pll_s && (cnt >= STALE)) state_nxt = ST_WAIT_CLK;
                    else if (cnt == TO_LAST)     timeout   = 1'b1;
                end
                ST_WAIT_CLK: begin
                    if (!pll_s)                       state_nxt = ST_WAIT_PLL;
                    else if (clk_s && (cnt >= STALE)) state_nxt = ST_SETTLE;
                    else if (cnt == TO_LAST)          timeout   = 1'b1;
                end
                ST_SETTLE: begin
                    if (!(pll_s && clk_s)) begin
                        state_nxt = ST_WAIT_PLL;
                    end else if (cnt == SETTLE_LAST) begin
                        state_nxt = ST_READY;
                        retry_nxt = '0;
                    end
                end
                ST_READY: begin
                    if (!(pll_s && clk_s)) state_nxt = ST_RESET_GTX;
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_RESET_GTX;
                end
            endcase

            if (timeout) begin
                if (retry < MAX_RETRY) begin
                    retry_nxt = retry + 4'd1;
                    state_nxt = ST_RESET_GTX;
                end else begin
                    state_nxt = ST_FAIL;
                end
            end

            if (restart_in[i]) begin
                state_nxt = ST_RESET_GTX;
                retry_nxt = '0;
            end

            if (restart_in[i] || (state_nxt != state))     cnt_nxt = '0;
            else if ((state == ST_READY) || (state == ST_FAIL)) cnt_nxt = cnt;
            else                                           cnt_nxt = cnt + CNT_ONE;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= ST_RESET_GTX;
                cnt      <= '0;
                retry    <= '0;
                gtx_q    <= 1'b1;
                clksrc_q <= 1'b1;
                ready_q  <= 1'b0;
                fail_q   <= 1'b0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                retry    <= retry_nxt;
                gtx_q    <= (state_nxt == ST_RESET_GTX) || (state_nxt == ST_FAIL);
                clksrc_q <= (state_nxt == ST_RESET_GTX) || (state_nxt == ST_WAIT_PLL) ||
                            (state_nxt == ST_FAIL);
                ready_q  <= (state_nxt == ST_READY);
                fail_q   <= (state_nxt == ST_FAIL);
            end
        end

        assign gtx_reset_out[i]    = gtx_q;
        assign clksrc_reset_out[i] = clksrc_q;
        assign lane_ready_out[i]   = ready_q;
        assign lane_fail_out[i]    = fail_q;

`ifdef SATAGTX_CLK_SEQ_STATUS_EN
        logic       lost;
        logic [7:0] loss_q;

        assign lost = (state == ST_READY) && !(pll_s && clk_s) && !restart_in[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                      loss_q <= '0;
            else if (lost && (loss_q != '1)) loss_q <= loss_q + 8'd1;
        end

        assign loss_cnt_out[8*i +: 8] = loss_q;
`else
        assign loss_cnt_out[8*i +: 8] = '0;
`endif
    end

endmodule

// File: tb/tb_satagtx_clk_seq.sv
// Scoreboard bench for satagtx_clk_seq: expectations are queued per cycle as stimulus is driven.
module tb_satagtx_clk_seq;

    localparam int unsigned N = 2;
`ifdef SATAGTX_CLK_SEQ_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    typedef enum int {S_GTX, S_CLKSRC, S_READY, S_FAIL, S_LOSS} sig_e;

    typedef struct {
        string       tag;
        int unsigned at;
        sig_e        sig;
        bit          lane;
        logic [31:0] val;
    } exp_t;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   plllkdet_in      = '0;
    logic [N-1:0]   clksrc_locked_in = '0;
    logic [N-1:0]   restart_in       = '0;
    logic [N-1:0]   gtx_reset_out;
    logic [N-1:0]   clksrc_reset_out;
    logic [N-1:0]   lane_ready_out;
    logic [N-1:0]   lane_fail_out;
    logic [8*N-1:0] loss_cnt_out;

    int unsigned cyc      = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    exp_t        sb[$];

    satagtx_clk_seq #(
        .C_NUM_LANES (2),
        .C_RST_PULSE (4),
        .C_LOCK_WAIT (8),
        .C_TIMEOUT   (32),
        .C_MAX_RETRY (2),
        .C_CNT_W     (17)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .plllkdet_in      (plllkdet_in),
        .clksrc_locked_in (clksrc_locked_in),
        .restart_in       (restart_in),
        .gtx_reset_out    (gtx_reset_out),
        .clksrc_reset_out (clksrc_reset_out),
        .lane_ready_out   (lane_ready_out),
        .lane_fail_out    (lane_fail_out),
        .loss_cnt_out     (loss_cnt_out)
    );

    always #5 clk = ~clk;

    // cyc == k means the DUT has taken k rising edges since rst_n was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(input sig_e sig, input bit lane);
        case (sig)
            S_GTX:    return 32'(gtx_reset_out[lane]);
            S_CLKSRC: return 32'(clksrc_reset_out[lane]);
            S_READY:  return 32'(lane_ready_out[lane]);
            S_FAIL:   return 32'(lane_fail_out[lane]);
            default:  return lane ? 32'(loss_cnt_out[15:8]) : 32'(loss_cnt_out[7:0]);
        endcase
    endfunction

    function automatic logic [31:0] loss_exp(input int unsigned n);
        if (!STATUS_EN) return 32'd0;
        return (n > 255) ? 32'd255 : 32'(n);
    endfunction

    task automatic expect_at(input string tag, input int unsigned at, input sig_e sig,
                             input bit lane, input logic [31:0] val);
        sb.push_back('{tag, at, sig, lane, val});
    endtask

    task automatic scan();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check_eq(sb[i].tag, sample(sb[i].sig, sb[i].lane), sb[i].val);
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                check_eq({sb[i].tag, "_late"}, cyc, sb[i].at);
                sb.delete(i);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) scan();
    endtask

    // Inputs change 1ns after the falling edge, once that edge's samples are taken.
    task automatic goto_cyc(input int unsigned c);
        while (cyc < c) tick();
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] pll, input logic [N-1:0] lck);
        rst_n            = 1'b0;
        plllkdet_in      = pll;
        clksrc_locked_in = lck;
        restart_in       = '0;
        #1;
        check_eq("rst_gtx",    32'(gtx_reset_out),    32'h3);
        check_eq("rst_clksrc", 32'(clksrc_reset_out), 32'h3);
        check_eq("rst_ready",  32'(lane_ready_out),   32'h0);
        check_eq("rst_fail",   32'(lane_fail_out),    32'h0);
        check_eq("rst_loss",   32'(loss_cnt_out),     32'h0);
        tick();
        tick();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2;
        // Both locks high from reset on both lanes.
        do_reset(2'b11, 2'b11);
        for (int l = 0; l < 2; l++) begin
            expect_at("A_gtx_c3",    3,  S_GTX,    l[0], 1);
            expect_at("A_gtx_c4",    4,  S_GTX,    l[0], 0);
            expect_at("A_clksrc_c6", 6,  S_CLKSRC, l[0], 1);
            expect_at("A_clksrc_c7", 7,  S_CLKSRC, l[0], 0);
            expect_at("A_ready_c17", 17, S_READY,  l[0], 0);
            expect_at("A_ready_c18", 18, S_READY,  l[0], 1);
            expect_at("A_fail_c18",  18, S_FAIL,   l[0], 0);
        end
        goto_cyc(30);

        // Lane1 clksrc lock glitch in READY, then lane0 restart with a settle-phase PLL glitch.
        expect_at("B_ready1_c32",  32, S_READY, 1, 1);
        expect_at("B_ready1_c33",  33, S_READY, 1, 0);
        expect_at("B_ready0_c33",  33, S_READY, 0, 1);
        expect_at("B_gtx1_c33",    33, S_GTX,   1, 1);
        expect_at("B_gtx1_c36",    36, S_GTX,   1, 1);
        expect_at("B_gtx1_c37",    37, S_GTX,   1, 0);
        expect_at("B_loss1_c33",   33, S_LOSS,  1, loss_exp(1));
        expect_at("B_ready1_c50",  50, S_READY, 1, 0);
        expect_at("B_ready1_c51",  51, S_READY, 1, 1);
        expect_at("B_ready0_c59",  59, S_READY, 0, 1);
        expect_at("B_ready0_c60",  60, S_READY, 0, 0);
        expect_at("B_gtx0_c60",    60, S_GTX,   0, 1);
        expect_at("B_gtx0_c63",    63, S_GTX,   0, 1);
        expect_at("B_gtx0_c64",    64, S_GTX,   0, 0);
        expect_at("B_clksrc0_c75", 75, S_CLKSRC, 0, 0);
        expect_at("B_clksrc0_c76", 76, S_CLKSRC, 0, 1);
        expect_at("B_clksrc0_c78", 78, S_CLKSRC, 0, 1);
        expect_at("B_clksrc0_c79", 79, S_CLKSRC, 0, 0);
        expect_at("B_ready0_c78",  78, S_READY, 0, 0);
        expect_at("B_ready0_c89",  89, S_READY, 0, 0);
        expect_at("B_ready0_c90",  90, S_READY, 0, 1);
        expect_at("B_loss0_c90",   90, S_LOSS,  0, 0);
        clksrc_locked_in[1] = 1'b0;
        goto_cyc(31); clksrc_locked_in[1] = 1'b1;
        goto_cyc(59); restart_in[0] = 1'b1;
        goto_cyc(60); restart_in[0] = 1'b0;
        goto_cyc(73); plllkdet_in[0] = 1'b0;
        goto_cyc(74); plllkdet_in[0] = 1'b1;
        goto_cyc(95);

        // Lane0 never locks: three reset pulses then FAIL; restarts on both lanes.
        do_reset(2'b10, 2'b11);
        expect_at("C_gtx0_c3",    3,   S_GTX,    0, 1);
        expect_at("C_gtx0_c4",    4,   S_GTX,    0, 0);
        expect_at("C_gtx0_c35",   35,  S_GTX,    0, 0);
        expect_at("C_gtx0_c36",   36,  S_GTX,    0, 1);
        expect_at("C_gtx0_c39",   39,  S_GTX,    0, 1);
        expect_at("C_gtx0_c40",   40,  S_GTX,    0, 0);
        expect_at("C_gtx0_c71",   71,  S_GTX,    0, 0);
        expect_at("C_gtx0_c72",   72,  S_GTX,    0, 1);
        expect_at("C_gtx0_c76",   76,  S_GTX,    0, 0);
        expect_at("C_gtx0_c107",  107, S_GTX,    0, 0);
        expect_at("C_fail0_c107", 107, S_FAIL,   0, 0);
        expect_at("C_fail0_c108", 108, S_FAIL,   0, 1);
        expect_at("C_gtx0_c108",  108, S_GTX,    0, 1);
        expect_at("C_clk0_c108",  108, S_CLKSRC, 0, 1);
        expect_at("C_ready1_c18", 18,  S_READY,  1, 1);
        expect_at("C_ready1_c108",108, S_READY,  1, 1);
        expect_at("C_fail1_c108", 108, S_FAIL,   1, 0);
        expect_at("C_fail0_c150", 150, S_FAIL,   0, 1);
        expect_at("C_fail0_c151", 151, S_FAIL,   0, 0);
        expect_at("C_gtx0_c154",  154, S_GTX,    0, 1);
        expect_at("C_gtx0_c155",  155, S_GTX,    0, 0);
        expect_at("C_fail0_c187", 187, S_FAIL,   0, 0);
        expect_at("C_fail0_c258", 258, S_FAIL,   0, 0);
        expect_at("C_fail0_c259", 259, S_FAIL,   0, 1);
        expect_at("C_ready1_c299",299, S_READY,  1, 1);
        expect_at("C_ready1_c300",300, S_READY,  1, 0);
        expect_at("C_clk1_c306",  306, S_CLKSRC, 1, 1);
        expect_at("C_clk1_c307",  307, S_CLKSRC, 1, 0);
        expect_at("C_gtx1_c338",  338, S_GTX,    1, 0);
        expect_at("C_gtx1_c339",  339, S_GTX,    1, 1);
        expect_at("C_clk1_c339",  339, S_CLKSRC, 1, 1);
        expect_at("C_gtx1_c342",  342, S_GTX,    1, 1);
        expect_at("C_gtx1_c343",  343, S_GTX,    1, 0);
        expect_at("C_fail1_c417", 417, S_FAIL,   1, 0);
        expect_at("C_fail1_c455", 455, S_FAIL,   1, 0);
        expect_at("C_fail1_c456", 456, S_FAIL,   1, 1);
        expect_at("C_fail0_c456", 456, S_FAIL,   0, 1);
        goto_cyc(150); restart_in[0] = 1'b1;
        goto_cyc(151); restart_in[0] = 1'b0;
        goto_cyc(299); restart_in[1] = 1'b1; clksrc_locked_in[1] = 1'b0;
        goto_cyc(300); restart_in[1] = 1'b0;
        goto_cyc(338); restart_in[1] = 1'b1;
        goto_cyc(339); restart_in[1] = 1'b0;
        goto_cyc(460);

        // 300 READY lock losses on lane1: counter saturates, or stays 0 when not built.
        do_reset(2'b11, 2'b11);
        goto_cyc(20);
        for (int n = 1; n <= 300; n++) begin
            int unsigned k;
            k = cyc;
            clksrc_locked_in[1] = 1'b0;
            expect_at("D_ready_hold",  k + 2,  S_READY, 1, 1);
            expect_at("D_ready_fall",  k + 3,  S_READY, 1, 0);
            expect_at("D_loss1",       k + 3,  S_LOSS,  1, loss_exp(n));
            expect_at("D_ready_again", k + 21, S_READY, 1, 1);
            goto_cyc(k + 1);
            clksrc_locked_in[1] = 1'b1;
            goto_cyc(k + 22);
        end
        expect_at("D_loss0", cyc + 1, S_LOSS, 0, 0);
        goto_cyc(cyc + 3);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
